// File: rtl/addsub_sat_seq.sv
// Chunk-serial signed adder/subtractor: CHUNK bits per clock through a registered carry,
// with optional saturation on signed overflow and valid/ready handshakes on both sides.
module addsub_sat_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             ovfl,
    output logic             cout
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d, s_q, s_d;
    logic             carry_q, carry_d, sat_q, sat_d;
    logic             ovfl_q, ovfl_d, cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             c_msb;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        s_d     = s_q;
        carry_d = carry_q;
        sat_d   = sat_q;
        ovfl_d  = ovfl_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        a_chunk   = a_q[cnt_q*CHUNK +: CHUNK];
        b_chunk   = b_q[cnt_q*CHUNK +: CHUNK];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the top bit of this chunk, recovered from its sum bit.
        c_msb     = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B ^ {WIDTH{sub}};
                    sat_d   = sat;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                sum_d[cnt_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                carry_d = chunk_sum[CHUNK];
                if (cnt_q == CW'(NCHUNK - 1)) begin
                    cout_d = chunk_sum[CHUNK];
                    ovfl_d = c_msb ^ chunk_sum[CHUNK];
                    if (sat_q && ovfl_d) begin
                        s_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
                    end else begin
                        s_d = sum_d;
                    end
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            sat_q   <= 1'b0;
            ovfl_q  <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            sat_q   <= sat_d;
            ovfl_q  <= ovfl_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign S         = s_q;
    assign ovfl      = ovfl_q;
    assign cout      = cout_q;
endmodule

// File: doc/addsub_sat_seq.md
Name: addsub_sat_seq

Overview:
Parametrised, multi-cycle, chunk-serial signed adder/subtractor with optional saturation. It is the next generation of the 16-bit CLA add/sub unit, generalised in width and in chunk size. It processes CHUNK bits per clock, carrying between chunks through a registered carry. It sits beside the ALU and serves multi-cycle arithmetic ops over a valid/ready handshake on both input and output.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK and at least 2.
CHUNK, 4, bits computed per clock; NCHUNK = WIDTH/CHUNK computation cycles per op.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands and mode are presented.
in_ready  output  1  block can accept an op.
A  input  WIDTH  operand A, two's complement.
B  input  WIDTH  operand B, two's complement.
sub  input  1  0 = A+B; 1 = A-B.
sat  input  1  1 = saturate on signed overflow; 0 = wrap.
out_valid  output  1  result fields are valid.
out_ready  input  1  consumer accepts the result.
S  output  WIDTH  result.
ovfl  output  1  signed overflow occurred; reported even when saturated.
cout  output  1  raw carry out of the MSB before saturation; for sub, 1 means no borrow.

Behaviour:
- Reset values: in_ready=1, out_valid=0, S=0, ovfl=0, cout=0; state=IDLE; chunk counter=0. Reset applies on any cycle, including mid-CALC and in DONE. The in-flight op is discarded and no out_valid pulse is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch A, B^{WIDTH{sub}}, sub and sat.
  - Set carry register = sub, counter=0, and go to CALC.
- CALC:
  - in_ready=0; in_valid is ignored; operand input pins are don't-care.
  - Each edge adds chunk[counter] of the latched operands plus the carry register.
  - Writes the chunk sum into the result register at bits [counter*CHUNK +: CHUNK].
  - Updates the carry register and increments counter.
  - The last chunk (counter=NCHUNK-1) also captures carry into the MSB (c_msb) and carry out (c_out).
  - Then go to DONE.
- Overflow and saturation, computed at the CALC->DONE transition:
  - ovfl = c_msb ^ c_out; cout = c_out.
  - If sat=1 and ovfl=1: S = 0 followed by all 1s (0x7FFF at W=16) when the latched A MSB = 0; otherwise S = 1 followed by all 0s (0x8000).
  - Else S = raw sum, modulo 2^WIDTH.
- DONE:
  - out_valid=1; S, ovfl and cout are held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid falls, state goes to IDLE, and in_ready=1 from the next cycle.
  - No same-cycle accept of a new op in DONE; throughput is one op per NCHUNK+2 cycles minimum.
- Latency: the accept edge is edge 0. out_valid rises after edge NCHUNK, so the result is visible in the cycle following NCHUNK edges (4 at defaults).
- S, ovfl and cout hold their last values after leaving DONE until the next op completes. Consumers qualify them with out_valid only.
- Boundary cases:
  - A=B=most-negative with sub=1 gives 0, ovfl=0.
  - Most-negative minus 1 with sat=1 gives 0x8000, ovfl=1.
  - CHUNK=WIDTH is legal (NCHUNK=1, single-cycle CALC).

Test Plan:
1. W=16, C=4: A=0x7FFF, B=0x7FFF, sub=0, sat=1 -> S=0x7FFF, ovfl=1, cout=0; out_valid rises exactly 4 edges after accept. Same op with sat=0 -> S=0xFFFE, ovfl=1.
2. A=0x8001, B=0x8001, sub=0, sat=1 -> S=0x8000, ovfl=1, cout=1. With sat=0 -> S=0x0002.
3. Subtraction: A=15, B=8, sub=1 -> S=7, cout=1, ovfl=0. A=8, B=0xFFF8 (-8), sub=1 -> S=16, ovfl=0.
4. Cross-chunk carry: 0x000F+0x0001 -> 0x0010, cout=0. 0xFFFF+0x0001 -> 0x0000, cout=1, ovfl=0, sat=1 has no effect.
5. Backpressure: hold out_ready=0 for 6 cycles after out_valid while driving in_valid=1 with new operands -> S stays stable and in_ready=0 throughout. Raise out_ready -> IDLE; the next op is accepted only from the following cycle.
6. Assert rst for 1 cycle after 2 CALC edges of 15+4 -> out_valid never pulses, in_ready=1 next cycle. Reissue 15+4 -> S=19, ovfl=0. Repeat tests 1 and 3 with C=16 (1 CALC cycle) and with W=8, C=2: 0x7F+0x01, sat=1 -> 0x7F, ovfl=1.
